// File: rtl/secondary_ray_queue.sv
// Secondary-ray queue: classifies refraction results, buffers valid secondary
// rays in a FIFO with incremented bounce count, and reports retired rays.
module secondary_ray_queue #(
  parameter int DEPTH       = 8,
  parameter int MAX_BOUNCES = 4,
  parameter int BOUNCE_W    = 3,
  parameter int PIX_W       = 16,
  parameter int COORD_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6*COORD_W-1:0]     in_ray,
  input  logic [1:0]               in_code,
  input  logic [BOUNCE_W-1:0]      in_bounce,
  input  logic [PIX_W-1:0]         in_pixel_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6*COORD_W-1:0]     out_ray,
  output logic [BOUNCE_W-1:0]      out_bounce,
  output logic [PIX_W-1:0]         out_pixel_id,
  output logic                     drop_valid,
  output logic [1:0]               drop_reason,
  output logic [PIX_W-1:0]         drop_pixel_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_total
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int RAY_W = 6 * COORD_W;
  localparam int ENT_W = RAY_W + BOUNCE_W + PIX_W;
  localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
  localparam logic [BOUNCE_W:0]   MAX_B_C = (BOUNCE_W+1)'(MAX_BOUNCES);

  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                drop_valid_q, drop_valid_d;
  logic [1:0]          drop_reason_q, drop_reason_d;
  logic [PIX_W-1:0]    drop_pix_q, drop_pix_d;
  logic [15:0]         drop_total_q, drop_total_d;

  logic                accept_s, drop_s, push_s, pop_s;
  logic [1:0]          reason_s;
  logic [BOUNCE_W:0]   bounce_inc_s;

  // Acceptance never depends on out_ready: a full queue stays closed.
  assign in_ready  = !rst && !flush && (count_q < DEPTH_C);
  assign out_valid = (count_q != {CW{1'b0}});
  assign {out_ray, out_bounce, out_pixel_id} = mem_q[rd_ptr_q];
  assign count         = count_q;
  assign drop_valid    = drop_valid_q;
  assign drop_reason   = drop_reason_q;
  assign drop_pixel_id = drop_pix_q;
  assign drop_total    = drop_total_q;

  // Classify the accepted item: bad code first, then bounce-depth limit.
  always_comb begin
    bounce_inc_s = {1'b0, in_bounce} + {{BOUNCE_W{1'b0}}, 1'b1};
    accept_s     = in_valid && in_ready;
    drop_s       = 1'b0;
    reason_s     = 2'b00;
    if (in_code != 2'b00) begin
      drop_s   = accept_s;
      reason_s = in_code;
    end else if (bounce_inc_s > MAX_B_C) begin
      drop_s   = accept_s;
      reason_s = 2'b00;
    end else begin
      drop_s   = 1'b0;
      reason_s = 2'b00;
    end
    push_s = accept_s && !drop_s;
    pop_s  = out_valid && out_ready && !flush;
  end

  // FIFO pointer and occupancy next-state; flush overrides any pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Drop report next-state; reason and pixel hold until the next retirement.
  always_comb begin
    drop_valid_d  = drop_s;
    drop_reason_d = drop_reason_q;
    drop_pix_d    = drop_pix_q;
    drop_total_d  = drop_total_q;
    if (drop_s) begin
      drop_reason_d = reason_s;
      drop_pix_d    = in_pixel_id;
      if (drop_total_q != 16'hFFFF) drop_total_d = drop_total_q + 16'd1;
      else                          drop_total_d = drop_total_q;
    end else begin
      drop_reason_d = drop_reason_q;
      drop_pix_d    = drop_pix_q;
      drop_total_d  = drop_total_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      drop_valid_q  <= 1'b0;
      drop_reason_q <= 2'b00;
      drop_pix_q    <= {PIX_W{1'b0}};
      drop_total_q  <= 16'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_valid_q  <= drop_valid_d;
      drop_reason_q <= drop_reason_d;
      drop_pix_q    <= drop_pix_d;
      drop_total_q  <= drop_total_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= {in_ray, bounce_inc_s[BOUNCE_W-1:0], in_pixel_id};
  end

endmodule
